// File: rtl/shifter_bist.sv
// Self-test engine for the 32-bit barrel shifter: LFSR vector generator,
// bit-serial reference model and result checker. SHIFTER_BIST_STOP_ON_FAIL_EN ends a run at the first mismatch.
module shifter_bist #(
  parameter int          WIDTH       = 32,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] sh_data,
  output logic [7:0]       sh_cmd,
  input  logic [WIDTH-1:0] sh_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_fail_idx,
  output logic [2:0]       dbg_state
);

  // start is a one-cycle request, accepted only in IDLE or DONE; a pulse
  // while busy is dropped with no side effects.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN1  = 3'd1,
    S_GEN2  = 3'd2,
    S_MODEL = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  state_t           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] vec_data_q, vec_data_d;
  logic [WIDTH-1:0] sh_data_q, sh_data_d;
  logic [7:0]       sh_cmd_q, sh_cmd_d;
  logic [WIDTH-1:0] model_q, model_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [15:0]      vec_idx_q, vec_idx_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      ff_q, ff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [31:0]      lfsr_next;
  logic [7:0]       gen_cmd;
  logic [WIDTH-1:0] model_step;
  logic             mismatch;
  logic             stop;

  always_comb begin
    lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    gen_cmd   = lfsr_next[7:0];
    // mode 11 is reserved; clearing bit 7 folds it onto arithmetic
    if (gen_cmd[7:6] == 2'b11) gen_cmd[7] = 1'b0;
  end

  always_comb begin
    model_step = model_q;
    if (sh_cmd_q[7:6] == 2'b10) begin
      model_step = sh_cmd_q[5] ? {model_q[0], model_q[WIDTH-1:1]}
                               : {model_q[WIDTH-2:0], model_q[WIDTH-1]};
    end else if (!sh_cmd_q[5]) begin
      model_step = {model_q[WIDTH-2:0], 1'b0};
    end else if (sh_cmd_q[6]) begin
      model_step = {model_q[WIDTH-1], model_q[WIDTH-1:1]};
    end else begin
      model_step = {1'b0, model_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    vec_data_d = vec_data_q;
    sh_data_d  = sh_data_q;
    sh_cmd_d   = sh_cmd_q;
    model_d    = model_q;
    cnt_d      = cnt_q;
    vec_idx_d  = vec_idx_q;
    err_d      = err_q;
    ff_d       = ff_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    mismatch   = 1'b0;
    stop       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_GEN1;
          lfsr_d    = SEED;
          vec_idx_d = 16'h0;
          err_d     = 16'h0;
          ff_d      = 16'hFFFF;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_GEN1: begin
        lfsr_d     = lfsr_next;
        vec_data_d = lfsr_next[WIDTH-1:0];
        state_d    = S_GEN2;
      end
      S_GEN2: begin
        lfsr_d    = lfsr_next;
        sh_data_d = vec_data_q;
        sh_cmd_d  = gen_cmd;
        model_d   = vec_data_q;
        cnt_d     = gen_cmd[4:0];
        state_d   = (gen_cmd[4:0] != 5'd0) ? S_MODEL : S_CHECK;
      end
      S_MODEL: begin
        model_d = model_step;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_CHECK;
      end
      S_CHECK: begin
        mismatch = (sh_out != model_q);
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (ff_q == 16'hFFFF) ff_d = vec_idx_q;
        end
        vec_idx_d = vec_idx_q + 16'd1;
`ifdef SHIFTER_BIST_STOP_ON_FAIL_EN
        stop = (vec_idx_q == LAST_IDX) || mismatch;
`else
        stop = (vec_idx_q == LAST_IDX);
`endif
        if (stop) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 16'h0);
        end else begin
          state_d = S_GEN1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      vec_data_q <= '0;
      sh_data_q  <= '0;
      sh_cmd_q   <= 8'h0;
      model_q    <= '0;
      cnt_q      <= 5'd0;
      vec_idx_q  <= 16'h0;
      err_q      <= 16'h0;
      ff_q       <= 16'hFFFF;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      vec_data_q <= vec_data_d;
      sh_data_q  <= sh_data_d;
      sh_cmd_q   <= sh_cmd_d;
      model_q    <= model_d;
      cnt_q      <= cnt_d;
      vec_idx_q  <= vec_idx_d;
      err_q      <= err_d;
      ff_q       <= ff_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign sh_data        = sh_data_q;
  assign sh_cmd         = sh_cmd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ff_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_shifter_bist.sv
// Scoreboard bench for shifter_bist: a behavioural shifter drives sh_out in
// several fault modes; run results and per-vector stimulus are checked against a bench model.
module tb_shifter_bist;
  localparam int          NV   = 64;
  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] sh_data;
  logic [7:0]  sh_cmd;
  logic [31:0] sh_out;
  logic        busy, done, pass;
  logic [15:0] err_count, first_fail_idx;
  logic [2:0]  dbg_state;
  logic [1:0]  out_mode;

  shifter_bist #(.WIDTH(32), .NUM_VECTORS(NV), .SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sh_data(sh_data), .sh_cmd(sh_cmd),
    .sh_out(sh_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] vec_q[$];
  logic [48:0] exp_q[$];
  logic [31:0] v_data[NV];
  logic [7:0]  v_cmd[NV];
  logic [31:0] last_data;
  logic [7:0]  last_cmd;
  logic        done_prev = 1'b0;

  function automatic logic [31:0] golden(input logic [31:0] d, input logic [7:0] c);
    logic [63:0]        t;
    logic signed [31:0] s;
    logic [4:0]         a;
    a = c[4:0];
    if (c[7:6] == 2'b10) begin
      t = {d, d};
      if (c[5]) begin
        t = t >> a;
        golden = t[31:0];
      end else begin
        t = t << a;
        golden = t[63:32];
      end
    end else if (c[7:6] == 2'b01 && c[5]) begin
      s = d;
      s = s >>> a;
      golden = s;
    end else begin
      golden = c[5] ? (d >> a) : (d << a);
    end
  endfunction

  function automatic logic [31:0] faulty(input logic [1:0] m, input logic [31:0] d,
                                         input logic [31:0] g);
    case (m)
      2'd0:    faulty = g;
      2'd1:    faulty = d;
      2'd2:    faulty = g & 32'h7FFF_FFFF;
      default: faulty = 32'h0;
    endcase
  endfunction

  always_comb sh_out = faulty(out_mode, sh_data, golden(sh_data, sh_cmd));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_table();
    logic [31:0] l;
    logic [7:0]  c;
    l = SEED;
    for (int i = 0; i < NV; i++) begin
      l = {1'b0, l[31:1]} ^ (l[0] ? TAPS : 32'h0);
      v_data[i] = l;
      l = {1'b0, l[31:1]} ^ (l[0] ? TAPS : 32'h0);
      c = l[7:0];
      if (c[7:6] == 2'b11) c[7] = 1'b0;
      v_cmd[i] = c;
    end
  endtask

  // Queue the expected vectors and run result for one run in a given sh_out mode.
  task automatic push_run(input logic [1:0] m);
    logic [15:0] e, ff;
    int          cycles;
    logic [31:0] g;
    e = 16'h0;
    ff = 16'hFFFF;
    cycles = 1;
    for (int i = 0; i < NV; i++) begin
      vec_q.push_back({v_data[i], v_cmd[i]});
      last_data = v_data[i];
      last_cmd = v_cmd[i];
      cycles += int'(v_cmd[i][4:0]) + 3;
      g = golden(v_data[i], v_cmd[i]);
      if (faulty(m, v_data[i], g) != g) begin
        e++;
        if (ff == 16'hFFFF) ff = 16'(i);
`ifdef SHIFTER_BIST_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    exp_q.push_back({e, ff, (e == 16'h0), 16'(cycles)});
  endtask

  task automatic do_start();
    @(negedge clk);
    start_cyc = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_timeout", done, 1'b1);
    @(negedge clk);
    chk("hold_sh_data", sh_data, last_data);
    chk("hold_sh_cmd", sh_cmd, last_cmd);
  endtask

  task automatic chk_reset_vals();
    chk("rst_sh_data", sh_data, 32'h0);
    chk("rst_sh_cmd", sh_cmd, 8'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_count", err_count, 16'h0);
    chk("rst_first_fail", first_fail_idx, 16'hFFFF);
    chk("rst_state", dbg_state, 3'd0);
  endtask

  // Monitor: per-vector stimulus at CHECK, run results on the rising edge of done.
  always @(negedge clk) begin
    if (!rst) begin
      if (dbg_state == 3'd4) begin
        if (vec_q.size() == 0) begin
          chk("vec_unexpected", 32'h1, 32'h0);
        end else begin
          logic [39:0] v;
          v = vec_q.pop_front();
          chk("vec_sh_data", sh_data, v[39:8]);
          chk("vec_sh_cmd", sh_cmd, v[7:0]);
        end
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("run_unexpected", 32'h1, 32'h0);
        end else begin
          logic [48:0] r;
          r = exp_q.pop_front();
          chk("run_err_count", err_count, r[48:33]);
          chk("run_first_fail", first_fail_idx, r[32:17]);
          chk("run_pass", pass, r[16]);
          chk("run_cycles", cyc - start_cyc, r[15:0]);
          chk("run_busy_low", busy, 1'b0);
        end
      end
    end
    done_prev = done;
  end

  initial begin
    build_table();
    rst = 1'b1;
    start = 1'b0;
    out_mode = 2'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // Asynchronous reset in the middle of a run, then a clean golden rerun.
    push_run(2'd0);
    do_start();
    chk("busy_after_start", busy, 1'b1);
    repeat (48) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    vec_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_run(2'd0);
    do_start();
    wait_done();

    // sh_out tied to sh_data.
    out_mode = 2'd1;
    push_run(2'd1);
    do_start();
    wait_done();

    // Stuck-at-0 on bit 31.
    out_mode = 2'd2;
    push_run(2'd2);
    do_start();
    wait_done();

    // Restart from DONE with errors pending must clear the run state.
    out_mode = 2'd0;
    push_run(2'd0);
    do_start();
    chk("restart_done_clr", done, 1'b0);
    chk("restart_err_clr", err_count, 16'h0);
    chk("restart_ff_clr", first_fail_idx, 16'hFFFF);
    chk("restart_busy", busy, 1'b1);
    wait_done();

    // A second start while busy is ignored.
    push_run(2'd0);
    do_start();
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_second_start", busy, 1'b1);
    wait_done();

    // sh_out forced to zero.
    out_mode = 2'd3;
    push_run(2'd3);
    do_start();
    wait_done();

    chk("vec_q_drained", vec_q.size(), 32'd0);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
